// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage pipeline.
// Holds the word-addressed data memory (2^ADDR_W x 32) and the MEM/WB
// pipeline register feeding write-back. It supports stall (hold) and
// flush (bubble) from the hazard unit.
// Optional feature macro: MEM_STAGE_ALIGN_CHECK_EN
//   When defined, a load or store with a non-zero byte offset is flagged as
//   misaligned. Its write is dropped and its register write is squashed.
//   When undefined, the byte offset is ignored and mem_misalign stays 0.
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_read_data,
    output logic [4:0]  mem_write_reg,
    output logic        mem_regwrite,
    output logic        mem_memtoreg,
    output logic        mem_misalign
);

    logic [31:0]       mem_array [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic              misalign;
    logic              wr_en;

    // Upper address bits are dropped, so accesses wrap around the array.
    assign word_idx = ex_alu_result[ADDR_W+1:2];
    assign rd_word  = mem_array[word_idx];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign = (ex_memread | ex_memwrite) & (ex_alu_result[1:0] != 2'b00) & ~flush;
`else
    assign misalign = 1'b0;
`endif

    // Writes are blocked while held in reset, stalled, flushed or misaligned.
    assign wr_en = ex_memwrite & ~stall & ~flush & ~misalign & rst_n;

    // Data memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[word_idx] <= ex_write_data;
        end
    end

    // MEM/WB register: flush bubbles, stall holds, otherwise capture.
    // rd_word is sampled before the write lands, so a simultaneous
    // read and write returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result <= '0;
            mem_read_data  <= '0;
            mem_write_reg  <= '0;
            mem_regwrite   <= 1'b0;
            mem_memtoreg   <= 1'b0;
            mem_misalign   <= 1'b0;
        end else if (flush) begin
            mem_alu_result <= '0;
            mem_read_data  <= '0;
            mem_write_reg  <= '0;
            mem_regwrite   <= 1'b0;
            mem_memtoreg   <= 1'b0;
            mem_misalign   <= 1'b0;
        end else if (!stall) begin
            mem_alu_result <= ex_alu_result;
            mem_read_data  <= ex_memread ? rd_word : 32'h0;
            mem_write_reg  <= ex_write_reg;
            mem_regwrite   <= ex_regwrite & ~misalign;
            mem_memtoreg   <= ex_memtoreg;
            mem_misalign   <= misalign;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage pipeline: holds the word-addressed data memory and the MEM/WB pipeline register. It sits directly upstream of write-back. It consumes the EX/MEM bundle, performs the load or store, and registers the ALU result, load data, destination register and WB controls for the write-back mux and register file. It also supports stall and flush from the hazard unit.

## Interface
Parameters:
- ADDR_W, 8, word-address width; data memory depth is 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_alu_result  in  32  byte address for loads/stores; pass-through result otherwise.
- ex_write_data  in  32  store data.
- ex_write_reg  in  5  destination register.
- ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite  in  1 each  control bits from EX/MEM.
- stall  in  1  hold the MEM/WB register; suppress the memory write.
- flush  in  1  load a bubble into MEM/WB; suppress the memory write.
- mem_alu_result  out  32  registered ALU result.
- mem_read_data  out  32  registered load data.
- mem_write_reg  out  5  registered destination register.
- mem_regwrite, mem_memtoreg  out  1 each  registered WB controls.
- mem_misalign  out  1  registered misaligned-access flag (see Configuration).

## Operation
- Word index = ex_alu_result[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Read is combinational from the array. The value is captured into mem_read_data at the clock edge only when ex_memread=1; otherwise mem_read_data captures 0.
- Write: array[index] <= ex_write_data at the clock edge when ex_memwrite=1, stall=0 and flush=0.
- If ex_memread and ex_memwrite are both 1, the write is performed and mem_read_data captures the pre-write contents.
- MEM/WB register update, by priority:
  - flush=1: bubble. All outputs become 0, including mem_misalign.
  - else stall=1: all outputs hold their values.
  - else: outputs take the ex_* values and the read result.
- flush overrides stall.
- Reset: all MEM/WB outputs are 0 immediately on rst_n falling, independent of clk. Memory contents are not reset and are undefined until written. No writes occur while rst_n=0.

## Timing
- Latency: 1 cycle from EX/MEM inputs to mem_* outputs.
- A store at edge N is visible to a load presented in the cycle after edge N. The load data appears on mem_read_data after edge N+1.
- stall and flush are sampled at the same edge as the data. A stalled instruction does not write memory, so its write is not repeated when the stall releases.
- Release of rst_n: the first capture happens at the first rising clk edge with rst_n=1.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN defined:
  - A load or store with ex_alu_result[1:0]!=0 and no flush is treated as misaligned.
  - Its memory write is suppressed, and mem_regwrite is captured as 0.
  - mem_misalign is captured as 1 for that instruction and follows the normal stall and flush rules.
- MEM_STAGE_ALIGN_CHECK_EN undefined:
  - Address bits [1:0] are ignored.
  - mem_misalign is constant 0.

## Test plan
- Reset: drive rst_n=0 mid-cycle with a valid load on the inputs -> all outputs become 0 immediately. After release, the next edge captures the inputs.
- Store then load: store 0xDEADBEEF at address 0x10, then load from 0x10 with regwrite=1, write_reg=5, memtoreg=1 -> one cycle later mem_read_data=0xDEADBEEF, mem_write_reg=5, mem_regwrite=1.
- Stall: load from 0x10 is captured; then stall=1 for 2 cycles while a store of 0x12345678 to 0x10 is presented -> outputs hold for those 2 cycles, and a later load from 0x10 still returns 0xDEADBEEF.
- Flush beats stall: flush=1 and stall=1 with a store of 0x1 to 0x20 -> all outputs 0, and a later load from 0x20 returns the prior contents.
- Wrap: with ADDR_W=8, store 0xA5A5A5A5 at 0x400, then load from 0x000 -> 0xA5A5A5A5. Non-memory op with alu_result=0x7 -> mem_alu_result=0x7 and mem_read_data=0.
- Alignment (macro defined): store of 0x55 to 0x13, then load from 0x10 -> contents unchanged. The store produces mem_misalign=1 and mem_regwrite=0. With the macro undefined, the same store writes word 0x10.
